// File: rtl/ravenoc_pkg.sv
// Shared NoC definitions: flit layout, flit types and the output-scheduler state encoding.
package ravenoc_pkg;

    localparam int N_VIRT_CHN      = 2;
    localparam int FLIT_TP_WIDTH   = 2;
    localparam int PKT_SZ_WIDTH    = 8;
    localparam int FLIT_DATA_WIDTH = 24;
    localparam int FLIT_WIDTH      = FLIT_TP_WIDTH + PKT_SZ_WIDTH + FLIT_DATA_WIDTH;

    localparam logic [PKT_SZ_WIDTH-1:0] MIN_SIZE_FLIT = 8'd1;

    typedef enum logic [FLIT_TP_WIDTH-1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } flit_type_t;

    // Flit type and packet size sit in the top bits of every flit.
    typedef struct packed {
        flit_type_t                   type_f;
        logic [PKT_SZ_WIDTH-1:0]      pkt_size;
        logic [FLIT_DATA_WIDTH-1:0]   data;
    } s_flit_head_data_t;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_HOLD,
        SCH_LOCKED
    } sched_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int  N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int         cand;
    logic [W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = W'(cand);
            if (!any && req[cand_idx]) begin
                any           = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/vc_out_scheduler.sv
// Wormhole output scheduler: one link shared by N_VC virtual channels, grant held HEAD..TAIL.
// Valid/ready: a flit moves on a VC when valid_i[v] & ready_o[v]; on the link when valid_o & ready_i.
module vc_out_scheduler
    import ravenoc_pkg::*;
#(
    parameter int  N_VC   = N_VIRT_CHN,
    parameter int  FLIT_W = FLIT_WIDTH,
    localparam int IDX_W  = $clog2(N_VC)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_VC*FLIT_W-1:0] fdata_i,
    input  logic [N_VC-1:0]        valid_i,
    output logic [N_VC-1:0]        ready_o,
    output logic [FLIT_W-1:0]      fdata_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [IDX_W-1:0]       gnt_vc_o,
    output logic                   busy_o,
    output logic                   err_o
);

    sched_st_t          state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt, hold_vc, hold_nxt, lock_vc, lock_nxt;
    logic [IDX_W-1:0]   gnt_idx, arb_idx;
    logic [N_VC-1:0]    head_vec, elig, bad, bad_q, arb_gnt, gnt_oh;
    logic               arb_any;
    logic [FLIT_W-1:0]  sel_flit;
    logic               sel_head, sel_tail, sel_single, out_xfer, err_fsm, err_idle;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_VC - 1)) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        head_vec = '0;
        for (int v = 0; v < N_VC; v++)
            head_vec[v] = (fdata_i[v*FLIT_W + FLIT_W-1 -: FLIT_TP_WIDTH] == HEAD_FLIT);
    end

    assign elig = valid_i & head_vec;
    // Non-HEAD traffic seen while idle is a protocol error; bad_q makes it a single pulse.
    assign bad  = (state == SCH_IDLE) ? (valid_i & ~head_vec) : '0;

    rr_arbiter #(.N(N_VC)) u_arb (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        if (!arst) begin
            case (state)
                SCH_IDLE: begin
                    gnt_oh  = arb_gnt;
                    gnt_idx = arb_idx;
                end
                SCH_HOLD, SCH_LOCKED: begin
                    gnt_idx = (state == SCH_HOLD) ? hold_vc : lock_vc;
                    for (int v = 0; v < N_VC; v++) gnt_oh[v] = (gnt_idx == IDX_W'(v));
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_flit = '0;
        for (int v = 0; v < N_VC; v++)
            if (gnt_oh[v]) sel_flit = fdata_i[v*FLIT_W +: FLIT_W];
    end

    assign fdata_o    = sel_flit;
    assign valid_o    = |(valid_i & gnt_oh);
    assign ready_o    = gnt_oh & {N_VC{ready_i}};
    assign gnt_vc_o   = gnt_idx;
    assign busy_o     = (state != SCH_IDLE);
    assign out_xfer   = valid_o & ready_i;
    assign sel_head   = (sel_flit[FLIT_W-1 -: FLIT_TP_WIDTH] == HEAD_FLIT);
    assign sel_tail   = (sel_flit[FLIT_W-1 -: FLIT_TP_WIDTH] == TAIL_FLIT);
    assign sel_single = sel_head &
                        (sel_flit[FLIT_W-FLIT_TP_WIDTH-1 -: PKT_SZ_WIDTH] == MIN_SIZE_FLIT);
    assign err_idle   = |(bad & ~bad_q);
    assign err_o      = ~arst & (err_fsm | err_idle);

    // rr_ptr only moves when a packet completes, so fairness is per packet.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_vc;
        lock_nxt  = lock_vc;
        err_fsm   = 1'b0;
        case (state)
            SCH_IDLE: begin
                if (arb_any) begin
                    if (!ready_i) begin
                        state_nxt = SCH_HOLD;
                        hold_nxt  = arb_idx;
                    end else if (sel_single) begin
                        rr_nxt = wrap_inc(arb_idx);
                    end else begin
                        state_nxt = SCH_LOCKED;
                        lock_nxt  = arb_idx;
                    end
                end
            end
            SCH_HOLD: begin
                if (!valid_i[hold_vc]) begin
                    err_fsm   = 1'b1;
                    state_nxt = SCH_IDLE;
                end else if (ready_i) begin
                    if (sel_single) begin
                        state_nxt = SCH_IDLE;
                        rr_nxt    = wrap_inc(hold_vc);
                    end else begin
                        state_nxt = SCH_LOCKED;
                        lock_nxt  = hold_vc;
                    end
                end
            end
            SCH_LOCKED: begin
                if (out_xfer) begin
                    if (sel_tail) begin
                        state_nxt = SCH_IDLE;
                        rr_nxt    = wrap_inc(lock_vc);
                    end else if (sel_head) begin
                        err_fsm = 1'b1;
                    end
                end
            end
            default: state_nxt = SCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state   <= SCH_IDLE;
            rr_ptr  <= '0;
            hold_vc <= '0;
            lock_vc <= '0;
            bad_q   <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            hold_vc <= hold_nxt;
            lock_vc <= lock_nxt;
            bad_q   <= bad;
        end
    end

`ifndef NO_ASSERTIONS
    a_ready_onehot: assert property (@(posedge clk) $onehot0(ready_o));
    a_gnt_stable: assert property (@(posedge clk) disable iff (arst)
        (valid_o && !ready_i) |=> $stable(gnt_oh));
`endif

endmodule

// File: tb/tb_vc_out_scheduler.sv
// Bench for vc_out_scheduler: directed packet scenarios plus random legal traffic vs. a packet-level model.
module tb_vc_out_scheduler;
    import ravenoc_pkg::*;

    localparam int N  = 2;
    localparam int FW = FLIT_WIDTH;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              arst;
    logic [N*FW-1:0]   fdata_i;
    logic [N-1:0]      valid_i;
    logic [N-1:0]      ready_o;
    logic [FW-1:0]     fdata_o;
    logic              valid_o;
    logic              ready_i;
    logic [IW-1:0]     gnt_vc_o;
    logic              busy_o;
    logic              err_o;

    int n_checks = 0;
    int n_fail   = 0;

    vc_out_scheduler #(.N_VC(N), .FLIT_W(FW)) dut (
        .clk      (clk),
        .arst     (arst),
        .fdata_i  (fdata_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .fdata_o  (fdata_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .gnt_vc_o (gnt_vc_o),
        .busy_o   (busy_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic flit_type_t ftype(input logic [FW-1:0] f);
        s_flit_head_data_t h;
        h = f;
        return h.type_f;
    endfunction

    function automatic int fsize(input logic [FW-1:0] f);
        s_flit_head_data_t h;
        h = f;
        return int'(h.pkt_size);
    endfunction

    function automatic logic [FW-1:0] mk_flit(input flit_type_t t, input int size);
        s_flit_head_data_t h;
        h.type_f   = t;
        h.pkt_size = 8'(size);
        h.data     = 24'($urandom);
        return h;
    endfunction

    task automatic set_vc(input int v, input logic vld, input logic [FW-1:0] f);
        valid_i[v]         = vld;
        fdata_i[v*FW +: FW] = f;
    endtask

    // Packet-level model: which VC owns the link, whether its head has gone, and the next-turn VC.
    int            m_owner;
    bit            m_started;
    int            m_turn;
    bit            m_bad_prev[N];
    bit            bad_now[N];
    int            e_g;
    logic [N-1:0]  e_ready;
    bit            e_valid;
    logic [FW-1:0] e_fdata;
    bit            e_busy, e_err;

    task automatic sample();
        logic [FW-1:0] f[N];
        @(negedge clk);
        for (int v = 0; v < N; v++) f[v] = fdata_i[v*FW +: FW];
        e_g = -1;
        if (!arst) begin
            if (m_owner >= 0) e_g = m_owner;
            else
                for (int k = 0; k < N; k++)
                    if (e_g < 0 && valid_i[(m_turn + k) % N] && ftype(f[(m_turn + k) % N]) == HEAD_FLIT)
                        e_g = (m_turn + k) % N;
        end
        e_ready = '0;
        e_valid = 1'b0;
        e_fdata = '0;
        if (e_g >= 0) begin
            e_ready[e_g] = ready_i;
            e_valid      = valid_i[e_g];
            e_fdata      = f[e_g];
        end
        e_busy = (m_owner >= 0);
        e_err  = 1'b0;
        for (int v = 0; v < N; v++) begin
            bad_now[v] = (m_owner < 0) && valid_i[v] && (ftype(f[v]) != HEAD_FLIT);
            if (!arst && bad_now[v] && !m_bad_prev[v]) e_err = 1'b1;
        end
        if (!arst && m_owner >= 0 && !m_started && !valid_i[m_owner]) e_err = 1'b1;
        if (!arst && m_started && e_valid && ready_i && ftype(e_fdata) == HEAD_FLIT) e_err = 1'b1;
        check_val("ready_o", 64'(ready_o), 64'(e_ready));
        check_val("valid_o", 64'(valid_o), 64'(e_valid));
        check_val("fdata_o", 64'(fdata_o), 64'(e_fdata));
        check_val("gnt_vc_o", 64'(gnt_vc_o), 64'((e_g < 0) ? 0 : e_g));
        check_val("busy_o", 64'(busy_o), 64'(e_busy));
        check_val("err_o", 64'(err_o), 64'(e_err));
    endtask

    task automatic advance();
        bit xfer, single;
        @(posedge clk);
        xfer   = e_valid && ready_i;
        single = (ftype(e_fdata) == HEAD_FLIT) && (fsize(e_fdata) == 1);
        if (arst) begin
            m_owner   = -1;
            m_started = 1'b0;
            m_turn    = 0;
            for (int v = 0; v < N; v++) m_bad_prev[v] = 1'b0;
        end else begin
            for (int v = 0; v < N; v++) m_bad_prev[v] = bad_now[v];
            if (m_owner < 0) begin
                if (e_g >= 0) begin
                    if (xfer && single) m_turn = (e_g + 1) % N;
                    else begin
                        m_owner   = e_g;
                        m_started = xfer;
                    end
                end
            end else if (!m_started) begin
                if (!valid_i[m_owner]) m_owner = -1;
                else if (xfer && single) begin
                    m_turn  = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (xfer) m_started = 1'b1;
            end else if (xfer && ftype(e_fdata) == TAIL_FLIT) begin
                m_turn    = (m_owner + 1) % N;
                m_owner   = -1;
                m_started = 1'b0;
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic clear_all();
        valid_i = '0;
        fdata_i = '0;
    endtask

    int            src_left[N];
    bit            src_valid[N];
    logic [FW-1:0] src_flit[N];

    initial begin
        logic [FW-1:0] b2;
        arst    = 1'b1;
        ready_i = 1'b0;
        clear_all();
        m_owner   = -1;
        m_started = 1'b0;
        m_turn    = 0;
        for (int v = 0; v < N; v++) m_bad_prev[v] = 1'b0;
        advance();
        sample();
        check_val("reset_busy", 64'(busy_o), 64'(0));
        check_val("reset_ready", 64'(ready_o), 64'(0));
        advance();
        arst    = 1'b0;
        ready_i = 1'b1;

        // 3-flit packet on VC0 while VC1 waits with a HEAD
        set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 3));
        sample(); check_val("t1_gnt_c0", 64'(gnt_vc_o), 64'(0)); advance();
        set_vc(0, 1'b1, mk_flit(BODY_FLIT, 0));
        set_vc(1, 1'b1, mk_flit(HEAD_FLIT, 1));
        sample(); check_val("t1_vc1_rdy_c1", 64'(ready_o[1]), 64'(0)); advance();
        set_vc(0, 1'b1, mk_flit(TAIL_FLIT, 0));
        sample(); check_val("t1_vc1_rdy_c2", 64'(ready_o[1]), 64'(0)); advance();
        set_vc(0, 1'b0, '0);
        sample();
        check_val("t1_gnt_c3", 64'(gnt_vc_o), 64'(1));
        check_val("t1_rdy_c3", 64'(ready_o), 64'(2'b10));
        advance();
        clear_all();

        // Continuous single-flit heads on both VCs alternate per packet
        for (int i = 0; i < 6; i++) begin
            set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 1));
            set_vc(1, 1'b1, mk_flit(HEAD_FLIT, 1));
            sample();
            check_val("t2_gnt", 64'(gnt_vc_o), 64'(i % 2));
            check_val("t2_busy", 64'(busy_o), 64'(0));
            advance();
        end
        clear_all();

        // Held head on VC1 is not stolen by a later VC0 head
        ready_i = 1'b0;
        set_vc(1, 1'b1, mk_flit(HEAD_FLIT, 1));
        for (int i = 0; i < 4; i++) begin
            if (i == 2) set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 4));
            sample();
            check_val("t3_gnt_hold", 64'(gnt_vc_o), 64'(1));
            advance();
        end
        ready_i = 1'b1;
        sample(); check_val("t3_release", 64'(ready_o), 64'(2'b10)); advance();
        set_vc(1, 1'b0, '0);

        // Backpressure mid-packet on VC0
        tick();
        set_vc(0, 1'b1, mk_flit(BODY_FLIT, 0));
        tick();
        b2 = mk_flit(BODY_FLIT, 0);
        set_vc(0, 1'b1, b2);
        set_vc(1, 1'b1, mk_flit(HEAD_FLIT, 1));
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check_val("t4_fdata_hold", 64'(fdata_o), 64'(b2));
            check_val("t4_gnt_hold", 64'(gnt_vc_o), 64'(0));
            advance();
        end
        ready_i = 1'b1;
        tick();
        set_vc(0, 1'b1, mk_flit(TAIL_FLIT, 0));
        tick();
        set_vc(0, 1'b0, '0);
        sample(); check_val("t4_next_gnt", 64'(gnt_vc_o), 64'(1)); advance();
        clear_all();

        // Stray BODY while idle, then HEAD inside a locked packet
        set_vc(1, 1'b1, mk_flit(BODY_FLIT, 0));
        for (int i = 0; i < 3; i++) begin
            sample();
            check_val("t5_err_pulse", 64'(err_o), 64'(i == 0));
            check_val("t5_no_ready", 64'(ready_o[1]), 64'(0));
            advance();
        end
        clear_all();
        tick();
        set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 3));
        tick();
        set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 3));
        sample();
        check_val("t5_err_lock", 64'(err_o), 64'(1));
        check_val("t5_fwd", 64'(valid_o), 64'(1));
        advance();
        set_vc(0, 1'b1, mk_flit(TAIL_FLIT, 0));
        sample(); check_val("t5_lock_kept", 64'(busy_o), 64'(1)); advance();
        clear_all();
        tick();

        // Reset in the middle of a 4-flit packet
        set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 4));
        tick();
        set_vc(0, 1'b1, mk_flit(BODY_FLIT, 0));
        tick();
        arst = 1'b1;
        sample();
        check_val("t6_rst_ready", 64'(ready_o), 64'(0));
        check_val("t6_rst_valid", 64'(valid_o), 64'(0));
        check_val("t6_rst_fdata", 64'(fdata_o), 64'(0));
        advance();
        arst = 1'b0;
        set_vc(0, 1'b1, mk_flit(HEAD_FLIT, 1));
        set_vc(1, 1'b1, mk_flit(HEAD_FLIT, 1));
        sample();
        check_val("t6_idle", 64'(busy_o), 64'(0));
        check_val("t6_ptr0", 64'(gnt_vc_o), 64'(0));
        advance();
        set_vc(0, 1'b0, '0);
        sample(); check_val("t6_vc1", 64'(gnt_vc_o), 64'(1)); advance();
        clear_all();

        // Random legal traffic with random backpressure and occasional reset
        for (int v = 0; v < N; v++) begin
            src_left[v]  = 0;
            src_valid[v] = 1'b0;
            src_flit[v]  = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            arst    = ($urandom_range(0, 299) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            for (int v = 0; v < N; v++) set_vc(v, src_valid[v], src_valid[v] ? src_flit[v] : '0);
            tick();
            for (int v = 0; v < N; v++) begin
                if (arst) begin
                    src_valid[v] = 1'b0;
                    src_left[v]  = 0;
                end else if (src_valid[v] && e_ready[v]) begin
                    src_valid[v] = 1'b0;
                    src_left[v]  = src_left[v] - 1;
                end
                if (!src_valid[v] && $urandom_range(0, 9) < 6) begin
                    if (src_left[v] == 0) begin
                        src_left[v] = $urandom_range(1, 4);
                        src_flit[v] = mk_flit(HEAD_FLIT, src_left[v]);
                    end else begin
                        src_flit[v] = mk_flit((src_left[v] == 1) ? TAIL_FLIT : BODY_FLIT,
                                              $urandom_range(0, 255));
                    end
                    src_valid[v] = 1'b1;
                end
            end
        end
        arst = 1'b0;
        clear_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
